// File: rtl/link_tx_pkg.sv
// link_tx_pkg: shared types for the credit-based link transmitter.
//   FLIT_W  : flit payload width (32)
//   ENTRY_W : width of one transmit FIFO entry ({last, data})
//   flit_t  : transmit FIFO entry
//   state_t : packet-framing FSM state
package link_tx_pkg;

  localparam int FLIT_W  = 32;
  localparam int ENTRY_W = FLIT_W + 1;

  typedef struct packed {
    logic              last;
    logic [FLIT_W-1:0] data;
  } flit_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_t;

endpackage

// File: rtl/link_tx_fifo.sv
// link_tx_fifo: synchronous transmit FIFO of flit_t entries (33 bits wide).
// Ports:
//   clk, rst       : clock, synchronous active-low reset
//   push/push_data : write request and entry
//   pop            : read request; pop_data shows the head entry
//   full, empty    : occupancy flags
// A full FIFO still takes a push when a pop happens in the same cycle.
// Pointers wrap naturally because DEPTH is a power of two.
module link_tx_fifo
  import link_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  flit_t push_data,
  input  logic  pop,
  output flit_t pop_data,
  output logic  full,
  output logic  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flit_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Qualify requests against the flags; a pop frees the slot a full push needs.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end

  // Occupancy flags derived from the registered count only.
  always_comb begin
    full     = (count == (AW+1)'(DEPTH));
    empty    = (count == '0);
    pop_data = mem[rd_ptr];
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/link_tx.sv
// link_tx: credit-based flit link transmitter.
// Ports:
//   clk, rst                       : clock, synchronous active-low reset
//   src_valid/src_data/src_last    : flit from the source; src_ready = FIFO not full
//   credit_in                      : one-cycle pulse, one downstream slot freed
//   data_out                       : registered link data (holds last sent flit)
//   diff_pair_p/diff_pair_n        : flit strobe pair, toggles once per sent flit
//   pkt_active                     : head of a packet sent, tail not yet
//   credit_err                     : sticky, credit arrived with counter full
// Optional (LINK_TX_STATS_EN defined):
//   tx_flit_cnt                    : sends since reset, wrapping
//   stall_cnt                      : cycles queued but out of credit, saturating
module link_tx
  import link_tx_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_valid,
  input  logic [FLIT_W-1:0] src_data,
  input  logic              src_last,
  output logic              src_ready,
  input  logic              credit_in,
  output logic [FLIT_W-1:0] data_out,
  output logic              diff_pair_p,
  output logic              diff_pair_n,
  output logic              pkt_active,
  output logic              credit_err
`ifdef LINK_TX_STATS_EN
  ,
  output logic [15:0]       tx_flit_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  flit_t         push_entry;
  flit_t         head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          send;
  logic [CW-1:0] credits;
  logic [CW-1:0] credits_nxt;
  logic          cerr_set;
  state_t        state;
  state_t        state_nxt;

  // Source handshake and send decision; no credit bypass, so credits are the registered count.
  always_comb begin
    src_ready       = ~fifo_full;
    push            = src_valid & ~fifo_full;
    push_entry.last = src_last;
    push_entry.data = src_data;
    send            = ~fifo_empty & (credits != '0);
  end

  link_tx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (send),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Credit counter next value; a send and a returning credit cancel out.
  always_comb begin
    credits_nxt = credits;
    cerr_set    = 1'b0;
    case ({send, credit_in})
      2'b10: credits_nxt = credits - CW'(1);
      2'b01: begin
        if (credits == CRED_MAX) begin
          cerr_set    = 1'b1;
          credits_nxt = credits;
        end else begin
          cerr_set    = 1'b0;
          credits_nxt = credits + CW'(1);
        end
      end
      default: credits_nxt = credits;
    endcase
  end

  // Packet framing: only sent flits move the state; credit stalls leave it alone.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (send && !head.last) begin
          state_nxt = BODY;
        end else begin
          state_nxt = IDLE;
        end
      end
      BODY: begin
        if (send && head.last) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = BODY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, credit and link output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      credits     <= CRED_MAX;
      credit_err  <= 1'b0;
      data_out    <= '0;
      diff_pair_p <= 1'b0;
      diff_pair_n <= 1'b1;
      pkt_active  <= 1'b0;
    end else begin
      state      <= state_nxt;
      credits    <= credits_nxt;
      credit_err <= credit_err | cerr_set;
      pkt_active <= (state_nxt == BODY);
      if (send) begin
        data_out    <= head.data;
        diff_pair_p <= ~diff_pair_p;
        diff_pair_n <= diff_pair_p;
      end else begin
        data_out    <= data_out;
        diff_pair_p <= diff_pair_p;
        diff_pair_n <= diff_pair_n;
      end
    end
  end

`ifdef LINK_TX_STATS_EN
  // Statistics: wrapping send count and saturating credit-stall count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_flit_cnt <= 16'd0;
      stall_cnt   <= 16'd0;
    end else begin
      if (send) begin
        tx_flit_cnt <= tx_flit_cnt + 16'd1;
      end else begin
        tx_flit_cnt <= tx_flit_cnt;
      end
      if (!fifo_empty && (credits == '0) && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end else begin
        stall_cnt <= stall_cnt;
      end
    end
  end
`endif

endmodule
